ghr_spec_ctrl: RTL
==================

Name: ghr_spec_ctrl

Overview:
Controller for the global history register (GHR) used by the branch predictor in the 5-stage pipeline. It keeps a speculative history that is updated at prediction time (IF), and a committed history that is updated at resolution time (EX). It holds a checkpoint FIFO of in-flight predicted branches so that a mispredict or pipeline flush restores the correct history in one cycle. The predictor index logic consumes ghr_spec_o.

Parameters:
HISTORY_WIDTH, 8, history length in bits (>=2)
DEPTH, 4, maximum in-flight predicted branches; power of 2, >=2

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  reset, synchronous, active-high
predict_valid_i  in  1  IF has a predicted branch this cycle
predict_taken_i  in  1  predicted direction
predict_ready_o  out  1  checkpoint slot available (= !full_o)
resolve_valid_i  in  1  EX resolves the oldest in-flight branch
resolve_taken_i  in  1  actual direction
resolve_mispredict_i  in  1  prediction was wrong; only meaningful with resolve_valid_i
flush_i  in  1  external flush (trap/exception); squashes all in-flight branches
ghr_spec_o  out  HISTORY_WIDTH  speculative history
ghr_commit_o  out  HISTORY_WIDTH  architectural (resolved) history
inflight_cnt_o  out  $clog2(DEPTH+1)  number of checkpoints held
full_o  out  1  inflight_cnt_o == DEPTH
empty_o  out  1  inflight_cnt_o == 0
resolve_err_o  out  1  one-cycle pulse: resolve_valid_i while empty

Behaviour:
- Reset (rst_ni=1 at clock edge): ghr_spec_o=0, ghr_commit_o=0, FIFO pointers=0, inflight_cnt_o=0, empty_o=1, full_o=0, resolve_err_o=0. Reset overrides every other input.
- All outputs are registered, except predict_ready_o and full_o/empty_o, which are decoded from the registered count. Latency from any update to the outputs is 1 cycle.
- Shift rule for every history update: new = {old[HISTORY_WIDTH-2:0], bit}.
- Predict accept = predict_valid_i && predict_ready_o && !mispredict_evt && !flush_i.
  - On accept: push the pre-shift ghr_spec_o into the FIFO tail, then ghr_spec <= shift(ghr_spec, predict_taken_i).
- Predict while full: the predict is dropped and no state changes. Upstream must stall on !predict_ready_o. There is no same-cycle pop-then-push bypass.
- Resolve (resolve_valid_i && !empty_o):
  - Pop the FIFO head.
  - ghr_commit <= shift(ghr_commit, resolve_taken_i).
  - Correctly predicted: ghr_spec is unchanged, apart from any concurrent accepted predict.
- Mispredict event (resolve valid, not empty, resolve_mispredict_i=1):
  - ghr_spec <= shift(popped checkpoint, resolve_taken_i).
  - The whole FIFO is cleared, because younger branches are squashed. inflight_cnt <= 0.
  - A same-cycle predict is dropped.
- Resolve while empty: no state change; resolve_err_o=1 for that cycle.
- flush_i (highest priority after reset):
  - The commit update from a same-cycle valid resolve is still applied first.
  - Then ghr_spec <= updated ghr_commit, FIFO cleared, same-cycle predict dropped.
- Count update: cnt' = cnt + push − pop when there is no clear; a clear forces 0. The count never exceeds DEPTH and never underflows.
- Pointers wrap modulo DEPTH. Wrap-around is transparent to behaviour.
- Invariant (when there is no mispredict/flush in flight): the FIFO head checkpoint, shifted by its resolved outcome, equals the next ghr_commit value whenever all older predictions were correct.

Test Plan:
1. Reset, then predict T,T,N with H=8 → ghr_spec_o=0x06, cnt=3, ghr_commit_o=0x00. Then resolve T,T,N (all correct) → ghr_commit_o=0x06, cnt=0, empty_o=1.
2. From spec=0x06 with 3 in flight, resolve oldest with taken=0, mispredict=1 → ghr_spec_o=0x00 (checkpoint 0x00 shifted with 0), ghr_commit_o=0x00, cnt=0. A same-cycle predict T is dropped.
3. Fill 4 predicts (T,N,T,N) → full_o=1, predict_ready_o=0. A 5th predict leaves ghr_spec_o=0x0A and cnt=4. One correct resolve → ready=1.
4. Same cycle: correct resolve (taken=1) plus predict T with cnt=2 → cnt stays 2, ghr_spec shifts by 1, ghr_commit shifts by 1.
5. flush_i with resolve T in the same cycle, commit=0x05 → ghr_commit_o=0x0B, ghr_spec_o=0x0B, cnt=0.
6. resolve_valid_i while empty → resolve_err_o pulses 1 cycle, all state unchanged. Run 20 push/pop cycles across pointer wrap, with checkpoints matching the scoreboard. Assert rst_ni mid-stream → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/ghr_spec_ctrl.sv
// Global history controller: speculative GHR updated at predict, committed GHR at resolve, checkpoint FIFO for recovery.
// Latency: every state update reaches the outputs 1 cycle later; ready/full/empty are decoded from the registered count.
// Backpressure: predict_ready_o drops when DEPTH checkpoints are held; a predict while full is dropped, with no pop-then-push bypass.
module ghr_spec_ctrl #(
    parameter int HISTORY_WIDTH = 8,
    parameter int DEPTH         = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       predict_valid_i,
    input  logic                       predict_taken_i,
    output logic                       predict_ready_o,
    input  logic                       resolve_valid_i,
    input  logic                       resolve_taken_i,
    input  logic                       resolve_mispredict_i,
    input  logic                       flush_i,
    output logic [HISTORY_WIDTH-1:0]   ghr_spec_o,
    output logic [HISTORY_WIDTH-1:0]   ghr_commit_o,
    output logic [$clog2(DEPTH+1)-1:0] inflight_cnt_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       resolve_err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [HISTORY_WIDTH-1:0] ckpt_q [DEPTH];
    logic [PW-1:0]            wr_ptr_q;
    logic [PW-1:0]            rd_ptr_q;
    logic [CW-1:0]            cnt_q;
    logic [HISTORY_WIDTH-1:0] spec_q;
    logic [HISTORY_WIDTH-1:0] commit_q;
    logic                     err_q;

    logic                     resolve_ok;
    logic                     mispredict_evt;
    logic                     push;
    logic [HISTORY_WIDTH-1:0] head_ckpt;
    logic [HISTORY_WIDTH-1:0] commit_nxt;

    // Oldest bit falls off the top, newest outcome enters at bit 0.
    function automatic logic [HISTORY_WIDTH-1:0] shift_in(
        input logic [HISTORY_WIDTH-1:0] h,
        input logic                     b
    );
        return {h[HISTORY_WIDTH-2:0], b};
    endfunction

    assign full_o          = (cnt_q == CW'(DEPTH));
    assign empty_o         = (cnt_q == '0);
    assign predict_ready_o = !full_o;

    // A resolve only acts when something is in flight; mispredict and flush both squash the same-cycle predict.
    assign resolve_ok     = resolve_valid_i && !empty_o;
    assign mispredict_evt = resolve_ok && resolve_mispredict_i;
    assign push           = predict_valid_i && predict_ready_o && !mispredict_evt && !flush_i;
    assign head_ckpt      = ckpt_q[rd_ptr_q];
    assign commit_nxt     = resolve_ok ? shift_in(commit_q, resolve_taken_i) : commit_q;

    // Checkpoint storage: the pre-shift speculative history of each accepted predict.
    always_ff @(posedge clk_i) begin
        if (!rst_ni && push) begin
            ckpt_q[wr_ptr_q] <= spec_q;
        end
    end

    // History registers, pointers and count; flush outranks mispredict, which outranks normal push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            spec_q   <= '0;
            commit_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q    <= resolve_valid_i && empty_o;
            commit_q <= commit_nxt;
            if (flush_i) begin
                spec_q   <= commit_nxt;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else if (mispredict_evt) begin
                spec_q   <= shift_in(head_ckpt, resolve_taken_i);
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push) begin
                    spec_q   <= shift_in(spec_q, predict_taken_i);
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (resolve_ok) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                cnt_q <= cnt_q + CW'(push) - CW'(resolve_ok);
            end
        end
    end

    assign ghr_spec_o     = spec_q;
    assign ghr_commit_o   = commit_q;
    assign inflight_cnt_o = cnt_q;
    assign resolve_err_o  = err_q;

endmodule
